fpu_addsub_sequencer: RTL
=========================

// Module: fpu_addsub_sequencer
// PURPOSE
//  Sequences the 80-bit add/sub/compare unit for FPU microcode: accepts one op (valid/ready), drives the unit's
//  operand/invert lines, holds them UNIT_LATENCY+1 cycles, captures the raw sum or compare flags, returns a response.
//  Fixes compare semantics (NaN unordered, +0==-0, both-negative order) and forms 8087 C3/C2/C0.
// PARAMETERS
//  WIDTH         80  operand/result width (extended precision: sign[79], exp[78:64], mantissa[63:0])
//  UNIT_LATENCY  1   clocks from stable unit operands to valid registered unit outputs
// PORTS
//  clk            in   1      single clock
//  reset          in   1      synchronous, active-high
//  flush          in   1      sync abort of in-flight op
//  req_valid      in   1      request present
//  req_ready      out  1      high only in IDLE
//  req_op         in   3      0 ADD,1 SUB(a-b),2 SUBR(b-a),3 COM,4 COMP(compare+pop),5 TST(a vs +0),6-7 illegal
//  req_a, req_b   in   WIDTH  operands
//  unit_a, unit_b out  WIDTH  registered operands to unit
//  unit_invert_b  out  1      registered sign-invert of unit_b
//  unit_result    in   WIDTH  unit registered raw sum
//  unit_eq/lt/gt  in   1      unit registered compare flags
//  resp_valid     out  1      response present
//  resp_ready     in   1      consumer accepts
//  resp_result    out  WIDTH  raw sum (ADD/SUB/SUBR); 0 for compares
//  resp_cc        out  3      {C3,C2,C0}; 000 for arithmetic
//  resp_pop       out  1      1 only for COMP
//  resp_err       out  1      illegal opcode
//  busy           out  1      state != IDLE
// BEHAVIOUR
//  Reset/flush: state IDLE, all outputs 0 (req_ready=1). Flush wins over every other event; in-flight op dropped.
//  FSM IDLE->WAIT->CAPT->RESP->IDLE. Accept = req_valid&&req_ready in cycle T.
//   IDLE: on accept latch op, unit_a/unit_b/unit_invert_b, NaN/zero flags; cnt<=UNIT_LATENCY; go WAIT.
//     Illegal op: no unit drive change, go RESP with resp_err=1, cc=000, result=0 (resp_valid at T+1).
//   WAIT: operands held; cnt-- each cycle; cnt==0 -> CAPT.   CAPT: sample unit outputs into resp_*; go RESP.
//   RESP: resp_valid=1, resp_* stable until resp_valid&&resp_ready, then IDLE. req_valid ignored here.
//  Latency: resp_valid first high in cycle T+UNIT_LATENCY+2. Peak throughput 1 op / UNIT_LATENCY+3 clocks.
//  Operand mapping: ADD a,b,inv0 | SUB a,b,inv1 | SUBR b,a,inv1 | COM/COMP a,b,inv0 | TST a,0,inv0.
//  Compare rules, priority order: NaN (exp==7FFF, mant[62:0]!=0) on either -> cc=111;
//   both zero (bits[78:0]==0, any sign) -> 100; unit_eq -> 100;
//   both signs 1 -> swap unit lt/gt (unit compares magnitude); lt -> 001, gt -> 000.
//  NaN/zero/sign classification computed from latched operands at accept, never from unit outputs.
//  resp_result is unit_result verbatim (no normalisation, no rounding); carry-out discarded.
// STRUCTURE
//  Shared package fpu_pkg: op encodings, CC_GT/LT/EQ/UNORD constants, exponent-all-ones constant,
//   is_nan/is_zero functions. FSM state enum local. No sub-module: classify logic is a package function.
// TESTING (UNIT_LATENCY=1, accept cycle T)
//  1 ADD a=b=3FFF_8000000000000000 -> unit_invert_b=0; resp_valid at T+3; resp_result=7FFF_0000000000000000, cc=000.
//  2 SUBR a=3FFF_8000..0 b=4000_8000..0 -> unit_a=4000_8000..0, unit_b=3FFF_8000..0, invert=1; pop=0.
//  3 COM a=C000_8000..0(-2) b=BFFF_8000..0(-1) -> cc=001; swapped a/b -> cc=000; a==b -> cc=100.
//  4 COMP a=0000_0..0 b=8000_0..0 -> cc=100, pop=1; TST a=7FFF_C000..0 (NaN) -> cc=111.
//  5 resp_ready low 5 cycles -> resp_* stable, req_ready=0, req_valid ignored; op 7 -> resp_err=1 at T+1.
//  6 flush in WAIT -> IDLE next cycle, no resp_valid; reset asserted in RESP -> outputs 0 next cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU add/sub/compare sequencing logic:
// opcode encodings, condition-code patterns and operand classification.
package fpu_pkg;

    localparam int FP_W = 80;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_SUBR = 3'd2,
        OP_COM  = 3'd3,
        OP_COMP = 3'd4,
        OP_TST  = 3'd5
    } op_e;

    // {C3,C2,C0}
    localparam logic [2:0] CC_GT    = 3'b000;
    localparam logic [2:0] CC_LT    = 3'b001;
    localparam logic [2:0] CC_EQ    = 3'b100;
    localparam logic [2:0] CC_UNORD = 3'b111;

    localparam logic [14:0] EXP_ONES = 15'h7FFF;

    // The explicit integer bit (mantissa[63]) plays no part in NaN detection.
    function automatic logic is_nan(
        input logic [14:0] e,
        input logic [62:0] f
    );
        return (e == EXP_ONES) && (f != '0);
    endfunction

    function automatic logic is_zero(input logic [78:0] m);
        return m == '0;
    endfunction

endpackage

// File: rtl/fpu_addsub_sequencer.sv
// Drives one op through the 80-bit add/sub/compare unit and
// turns its raw sum or magnitude flags into a microcode response.
module fpu_addsub_sequencer
    import fpu_pkg::*;
#(
    parameter int WIDTH        = 80,
    parameter int UNIT_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    output logic             unit_invert_b,
    input  logic [WIDTH-1:0] unit_result,
    input  logic             unit_eq,
    input  logic             unit_lt,
    input  logic             unit_gt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [2:0]       resp_cc,
    output logic             resp_pop,
    output logic             resp_err,
    output logic             busy
);

    localparam int CW = $clog2(UNIT_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic             nan_q, nan_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] unit_a_q, unit_a_d;
    logic [WIDTH-1:0] unit_b_q, unit_b_d;
    logic             inv_q, inv_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [2:0]       resp_cc_q, resp_cc_d;
    logic             resp_pop_q, resp_pop_d;
    logic             resp_err_q, resp_err_d;

    logic [WIDTH-1:0] map_x, map_y;
    logic             map_inv, map_ill;
    logic             is_arith, a_below;

    always_comb begin
        map_x   = req_a;
        map_y   = req_b;
        map_inv = 1'b0;
        map_ill = 1'b0;
        case (req_op)
            OP_ADD:  ;
            OP_SUB:  map_inv = 1'b1;
            OP_SUBR: begin
                map_x   = req_b;
                map_y   = req_a;
                map_inv = 1'b1;
            end
            OP_COM, OP_COMP: ;
            OP_TST:  map_y = '0;
            default: map_ill = 1'b1;
        endcase
    end

    always_comb begin
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_SUBR);
        // The unit orders magnitudes; two negatives reverse the order.
        a_below  = neg_q ? unit_gt : unit_lt;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        nan_d         = nan_q;
        zero_d        = zero_q;
        neg_d         = neg_q;
        unit_a_d      = unit_a_q;
        unit_b_d      = unit_b_q;
        inv_d         = inv_q;
        req_ready_d   = req_ready_q;
        busy_d        = busy_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_cc_d     = resp_cc_q;
        resp_pop_d    = resp_pop_q;
        resp_err_d    = resp_err_q;
        unique case (state_q)
            S_IDLE: if (req_valid && req_ready_q) begin
                req_ready_d = 1'b0;
                busy_d      = 1'b1;
                if (map_ill) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_err_d    = 1'b1;
                    resp_cc_d     = CC_GT;
                    resp_result_d = '0;
                    resp_pop_d    = 1'b0;
                end else begin
                    state_d  = S_WAIT;
                    cnt_d    = CW'(UNIT_LATENCY);
                    op_d     = op_e'(req_op);
                    unit_a_d = map_x;
                    unit_b_d = map_y;
                    inv_d    = map_inv;
                    nan_d    = is_nan(map_x[78:64], map_x[62:0]) ||
                               is_nan(map_y[78:64], map_y[62:0]);
                    zero_d   = is_zero(map_x[78:0]) &&
                               is_zero(map_y[78:0]);
                    neg_d    = map_x[79] && map_y[79];
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_pop_d   = (op_q == OP_COMP);
                if (is_arith) begin
                    resp_result_d = unit_result;
                    resp_cc_d     = CC_GT;
                end else begin
                    resp_result_d = '0;
                    if (nan_q)        resp_cc_d = CC_UNORD;
                    else if (zero_q)  resp_cc_d = CC_EQ;
                    else if (unit_eq) resp_cc_d = CC_EQ;
                    else if (a_below) resp_cc_d = CC_LT;
                    else              resp_cc_d = CC_GT;
                end
            end
            S_RESP: if (resp_ready) begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            op_q          <= OP_ADD;
            nan_q         <= 1'b0;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            inv_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_result_q <= '0;
            resp_cc_q     <= '0;
            resp_pop_q    <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            nan_q         <= nan_d;
            zero_q        <= zero_d;
            neg_q         <= neg_d;
            unit_a_q      <= unit_a_d;
            unit_b_q      <= unit_b_d;
            inv_q         <= inv_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_cc_q     <= resp_cc_d;
            resp_pop_q    <= resp_pop_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign unit_a        = unit_a_q;
    assign unit_b        = unit_b_q;
    assign unit_invert_b = inv_q;
    assign resp_valid    = resp_valid_q;
    assign resp_result   = resp_result_q;
    assign resp_cc       = resp_cc_q;
    assign resp_pop      = resp_pop_q;
    assign resp_err      = resp_err_q;

endmodule
